faerie_mem_arbiter: RTL and testbench

FAERIE_MEM_ARBITER -- requirements
Module: faerie_mem_arbiter

---
 rtl/faerie_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_faerie_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/faerie_mem_arbiter.sv
// Two-port memory arbiter: combinational grant with lock/round-robin priority,
// starvation override after max_wait denied cycles, and per-port read return routing.
module faerie_mem_arbiter #(
  parameter int sync_read = 1,
  parameter int max_wait  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [7:0]  p0_rdata,
  output logic [7:0]  p1_rdata,
  output logic        re,
  output logic        we,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata
);

  localparam logic [3:0] MaxWait = 4'(max_wait);

  logic       lockValid_q, lockValid_d;
  logic       lockOwner_q, lockOwner_d;
  logic       lastGnt_q, lastGnt_d;
  logic [3:0] wait0_q, wait0_d;
  logic [3:0] wait1_q, wait1_d;
  logic       pendValid_q, pendValid_d;
  logic       pendPort_q, pendPort_d;

  logic        gnt0, gnt1, anyGnt;
  logic        selWe, selLock;
  logic [15:0] selAddr;
  logic [7:0]  selWdata;

  // Lock owner wins a tie unless the other port has waited max_wait cycles.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (p0_req && !p1_req) begin
        gnt0 = 1'b1;
      end else if (p1_req && !p0_req) begin
        gnt1 = 1'b1;
      end else if (p0_req && p1_req) begin
        if (lockValid_q) begin
          if (!lockOwner_q) begin
            if (wait1_q == MaxWait) gnt1 = 1'b1;
            else                    gnt0 = 1'b1;
          end else begin
            if (wait0_q == MaxWait) gnt0 = 1'b1;
            else                    gnt1 = 1'b1;
          end
        end else if (lastGnt_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
    end
  end

  assign anyGnt   = gnt0 | gnt1;
  assign selWe    = gnt1 ? p1_we    : p0_we;
  assign selLock  = gnt1 ? p1_lock  : p0_lock;
  assign selAddr  = gnt1 ? p1_addr  : p0_addr;
  assign selWdata = gnt1 ? p1_wdata : p0_wdata;

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;
  assign re     = anyGnt & ~selWe;
  assign we     = anyGnt & selWe;
  assign addr   = anyGnt ? selAddr  : 16'h0000;
  assign wdata  = anyGnt ? selWdata : 8'h00;

  // Every grant re-decides ownership, so an idle cycle, an unlocked grant or an
  // override all drop the lock.
  always_comb begin
    lastGnt_d   = anyGnt ? gnt1 : lastGnt_q;
    lockValid_d = anyGnt & selLock;
    lockOwner_d = anyGnt ? gnt1 : lockOwner_q;
    pendValid_d = re;
    pendPort_d  = gnt1;

    wait0_d = wait0_q;
    if (!p0_req || gnt0)        wait0_d = 4'd0;
    else if (wait0_q < MaxWait) wait0_d = wait0_q + 4'd1;

    wait1_d = wait1_q;
    if (!p1_req || gnt1)        wait1_d = 4'd0;
    else if (wait1_q < MaxWait) wait1_d = wait1_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockValid_q <= 1'b0;
      lockOwner_q <= 1'b0;
      lastGnt_q   <= 1'b1;
      wait0_q     <= 4'd0;
      wait1_q     <= 4'd0;
      pendValid_q <= 1'b0;
      pendPort_q  <= 1'b0;
    end else begin
      lockValid_q <= lockValid_d;
      lockOwner_q <= lockOwner_d;
      lastGnt_q   <= lastGnt_d;
      wait0_q     <= wait0_d;
      wait1_q     <= wait1_d;
      pendValid_q <= pendValid_d;
      pendPort_q  <= pendPort_d;
    end
  end

  logic syncRv0, syncRv1, combRv0, combRv1;
  assign syncRv0 = pendValid_q & ~pendPort_q;
  assign syncRv1 = pendValid_q & pendPort_q;
  assign combRv0 = re & gnt0;
  assign combRv1 = re & gnt1;

  assign p0_rvalid = (sync_read != 0) ? syncRv0 : combRv0;
  assign p1_rvalid = (sync_read != 0) ? syncRv1 : combRv1;
  assign p0_rdata  = p0_rvalid ? rdata : 8'h00;
  assign p1_rdata  = p1_rvalid ? rdata : 8'h00;

endmodule

// File: tb/tb_faerie_mem_arbiter.sv
// Scoreboard bench for faerie_mem_arbiter: a registered-read and a combinational-read
// instance share stimulus; expectations are queued at issue and popped by a monitor.
module tb_faerie_mem_arbiter;

  typedef struct {
    logic        r0, w0, l0;
    logic [15:0] a0;
    logic        r1, w1, l1;
    logic [15:0] a1;
    logic [7:0]  wd1;
    logic [7:0]  rd;
    logic [1:0]  g;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    logic        re, we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } gntExp_t;

  typedef struct {
    logic       port;
    logic [7:0] data;
  } retExp_t;

  logic        clk, rst;
  logic        p0Req, p0We, p0Lock, p1Req, p1We, p1Lock;
  logic [15:0] p0Addr, p1Addr;
  logic [7:0]  p0Wdata, p1Wdata, memRdata;

  logic        sGnt0, sGnt1, sRv0, sRv1, sRe, sWe;
  logic [7:0]  sRd0, sRd1, sWdata;
  logic [15:0] sAddr;
  logic        cGnt0, cGnt1, cRv0, cRv1, cRe, cWe;
  logic [7:0]  cRd0, cRd1, cWdata;
  logic [15:0] cAddr;

  int nChecks = 0;
  int nErrors = 0;

  gntExp_t gntQ[$];
  retExp_t syncQ[$];
  retExp_t combQ[$];
  vec_t    vecs[$];

  faerie_mem_arbiter #(.sync_read(1), .max_wait(4)) dutSync (
    .clk(clk), .rst(rst),
    .p0_req(p0Req), .p0_we(p0We), .p0_lock(p0Lock), .p0_addr(p0Addr), .p0_wdata(p0Wdata),
    .p1_req(p1Req), .p1_we(p1We), .p1_lock(p1Lock), .p1_addr(p1Addr), .p1_wdata(p1Wdata),
    .p0_gnt(sGnt0), .p1_gnt(sGnt1), .p0_rvalid(sRv0), .p1_rvalid(sRv1),
    .p0_rdata(sRd0), .p1_rdata(sRd1), .re(sRe), .we(sWe), .addr(sAddr),
    .wdata(sWdata), .rdata(memRdata)
  );

  faerie_mem_arbiter #(.sync_read(0), .max_wait(4)) dutComb (
    .clk(clk), .rst(rst),
    .p0_req(p0Req), .p0_we(p0We), .p0_lock(p0Lock), .p0_addr(p0Addr), .p0_wdata(p0Wdata),
    .p1_req(p1Req), .p1_we(p1We), .p1_lock(p1Lock), .p1_addr(p1Addr), .p1_wdata(p1Wdata),
    .p0_gnt(cGnt0), .p1_gnt(cGnt1), .p0_rvalid(cRv0), .p1_rvalid(cRv1),
    .p0_rdata(cRd0), .p1_rdata(cRd1), .re(cRe), .we(cWe), .addr(cAddr),
    .wdata(cWdata), .rdata(memRdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic w0, input logic l0, input logic [15:0] a0,
                              input logic r1, input logic w1, input logic l1, input logic [15:0] a1,
                              input logic [7:0] wd1, input logic [7:0] rd, input logic [1:0] g);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1;
    v.wd1 = wd1; v.rd = rd; v.g = g;
    return v;
  endfunction

  task automatic driveIdle();
    p0Req = 1'b0; p0We = 1'b0; p0Lock = 1'b0; p0Addr = 16'h0000;
    p1Req = 1'b0; p1We = 1'b0; p1Lock = 1'b0; p1Addr = 16'h0000;
    p1Wdata = 8'h00; memRdata = 8'h00;
  endtask

  // Drives one cycle of stimulus and queues what the grant and read returns must look like.
  task automatic applyStimulus(input vec_t v, input logic [7:0] nextRd);
    gntExp_t ge;
    retExp_t re0;
    logic    isRead;
    @(posedge clk);
    #1;
    p0Req = v.r0; p0We = v.w0; p0Lock = v.l0; p0Addr = v.a0;
    p1Req = v.r1; p1We = v.w1; p1Lock = v.l1; p1Addr = v.a1;
    p1Wdata = v.wd1; memRdata = v.rd;
    if (v.g != 2'b00) begin
      ge.gnt   = v.g;
      ge.we    = v.g[1] ? v.w1 : v.w0;
      ge.re    = ~ge.we;
      ge.addr  = v.g[1] ? v.a1 : v.a0;
      ge.wdata = v.g[1] ? v.wd1 : 8'hA5;
      gntQ.push_back(ge);
      isRead = ge.re;
      if (isRead) begin
        re0.port = v.g[1];
        re0.data = v.rd;
        combQ.push_back(re0);
        re0.data = nextRd;
        syncQ.push_back(re0);
      end
    end
  endtask

  // Monitor: compares whatever the DUTs present against the head of each queue.
  initial begin
    gntExp_t e;
    retExp_t r;
    forever begin
      @(negedge clk);
      if (sGnt0 | sGnt1 | cGnt0 | cGnt1) begin
        if (gntQ.size() == 0) begin
          checkOutput("unexpected grant", 32'({cGnt1, cGnt0, sGnt1, sGnt0}), 32'd0);
        end else begin
          e = gntQ.pop_front();
          checkOutput("sync gnt",   32'({sGnt1, sGnt0}), 32'(e.gnt));
          checkOutput("sync re",    32'(sRe),    32'(e.re));
          checkOutput("sync we",    32'(sWe),    32'(e.we));
          checkOutput("sync addr",  32'(sAddr),  32'(e.addr));
          checkOutput("sync wdata", 32'(sWdata), 32'(e.wdata));
          checkOutput("comb gnt",   32'({cGnt1, cGnt0}), 32'(e.gnt));
          checkOutput("comb addr",  32'(cAddr),  32'(e.addr));
        end
      end
      if (sRv0 | sRv1) begin
        if (syncQ.size() == 0) begin
          checkOutput("unexpected sync rvalid", 32'({sRv1, sRv0}), 32'd0);
        end else begin
          r = syncQ.pop_front();
          checkOutput("sync rvalid port", 32'({sRv1, sRv0}), r.port ? 32'd2 : 32'd1);
          checkOutput("sync rdata", 32'(r.port ? sRd1 : sRd0), 32'(r.data));
        end
      end
      if (cRv0 | cRv1) begin
        if (combQ.size() == 0) begin
          checkOutput("unexpected comb rvalid", 32'({cRv1, cRv0}), 32'd0);
        end else begin
          r = combQ.pop_front();
          checkOutput("comb rvalid port", 32'({cRv1, cRv0}), r.port ? 32'd2 : 32'd1);
          checkOutput("comb rdata", 32'(r.port ? cRd1 : cRd0), 32'(r.data));
        end
      end
      if (!sRv0) checkOutput("sync p0_rdata idle", 32'(sRd0), 32'd0);
      if (!sRv1) checkOutput("sync p1_rdata idle", 32'(sRd1), 32'd0);
      if (!cRv0) checkOutput("comb p0_rdata idle", 32'(cRd0), 32'd0);
      if (!cRv1) checkOutput("comb p1_rdata idle", 32'(cRd1), 32'd0);
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " sync gnt/rv/re/we"}, 32'({sGnt1, sGnt0, sRv1, sRv0, sRe, sWe}), 32'd0);
    checkOutput({tag, " sync addr"},  32'(sAddr),  32'd0);
    checkOutput({tag, " sync wdata"}, 32'(sWdata), 32'd0);
    checkOutput({tag, " sync rdata"}, 32'({sRd1, sRd0}), 32'd0);
    checkOutput({tag, " comb gnt/rv/re/we"}, 32'({cGnt1, cGnt0, cRv1, cRv0, cRe, cWe}), 32'd0);
    checkOutput({tag, " comb addr/rdata"}, 32'({cAddr, cRd1, cRd0}), 32'd0);
  endtask

  initial begin
    // Port 0 write data is constant throughout.
    p0Wdata = 8'hA5;
    driveIdle();
    rst = 1'b1;
    p0Req = 1'b1; p1Req = 1'b1; p0Addr = 16'h1111; p1Addr = 16'h2222; memRdata = 8'hEE;
    #2;
    checkAllZero("reset");

    // Alternating ties, single p0 read, p1 write, lock with starvation override,
    // p1 lock, idle lock release.
    vecs.push_back(mk(1,0,0,16'h1001, 1,0,0,16'h2001, 8'h5B, 8'h11, 2'b01));
    vecs.push_back(mk(1,0,0,16'h1002, 1,0,0,16'h2002, 8'h5B, 8'h22, 2'b10));
    vecs.push_back(mk(1,0,0,16'h1003, 1,0,0,16'h2003, 8'h5B, 8'h33, 2'b01));
    vecs.push_back(mk(1,0,0,16'h1004, 1,0,0,16'h2004, 8'h5B, 8'h44, 2'b10));
    vecs.push_back(mk(1,0,0,16'h1234, 0,0,0,16'h0000, 8'h5B, 8'h55, 2'b01));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,0,16'h0000, 8'h5B, 8'h5A, 2'b00));
    vecs.push_back(mk(0,0,0,16'h0000, 1,1,0,16'hBEEF, 8'h77, 8'h66, 2'b10));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,0,16'h0000, 8'h5B, 8'h00, 2'b00));
    vecs.push_back(mk(1,0,1,16'h3009, 1,0,0,16'h4009, 8'h5B, 8'h09, 2'b01));
    vecs.push_back(mk(1,0,1,16'h300A, 1,0,0,16'h400A, 8'h5B, 8'h0A, 2'b01));
    vecs.push_back(mk(1,0,1,16'h300B, 1,0,0,16'h400B, 8'h5B, 8'h0B, 2'b01));
    vecs.push_back(mk(1,0,1,16'h300C, 1,0,0,16'h400C, 8'h5B, 8'h0C, 2'b01));
    vecs.push_back(mk(1,0,1,16'h300D, 1,0,0,16'h400D, 8'h5B, 8'h0D, 2'b10));
    vecs.push_back(mk(0,0,0,16'h0000, 1,0,1,16'h5EE0, 8'h5B, 8'hC3, 2'b10));
    vecs.push_back(mk(1,0,0,16'h600F, 1,0,1,16'h700F, 8'h5B, 8'h0F, 2'b10));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,0,16'h0000, 8'h5B, 8'h10, 2'b00));
    vecs.push_back(mk(1,0,0,16'h6011, 1,0,0,16'h7011, 8'h5B, 8'h17, 2'b01));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,0,16'h0000, 8'h5B, 8'h18, 2'b00));
    // After the mid-cycle reset: tie must go to p0 again.
    vecs.push_back(mk(1,0,0,16'h8001, 1,0,0,16'h9001, 8'h5B, 8'h21, 2'b01));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,0,16'h0000, 8'h5B, 8'h22, 2'b00));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,0,16'h0000, 8'h5B, 8'h00, 2'b00));

    @(posedge clk);
    #1;
    driveIdle();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) applyStimulus(vecs[i], vecs[i+1].rd);

    // p0 read granted, then reset asserted before the next edge.
    @(posedge clk);
    #1;
    p0Req = 1'b1; p0We = 1'b0; p0Addr = 16'hABCD; memRdata = 8'h99;
    #1;
    checkOutput("pre-reset sync gnt", 32'({sGnt1, sGnt0}), 32'd1);
    checkOutput("pre-reset sync re/addr", 32'({sRe, sAddr}), 32'h1ABCD);
    checkOutput("pre-reset comb rvalid/rdata", 32'({cRv1, cRv0, cRd0}), 32'h199);
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("mid-cycle reset");
    @(posedge clk);
    #1;
    driveIdle();
    rst = 1'b0;

    for (int i = 18; i < 20; i++) applyStimulus(vecs[i], vecs[i+1].rd);
    applyStimulus(vecs[20], 8'h00);

    @(posedge clk);
    #2;
    checkOutput("grant queue drained", 32'(gntQ.size()), 32'd0);
    checkOutput("sync return queue drained", 32'(syncQ.size()), 32'd0);
    checkOutput("comb return queue drained", 32'(combQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
